// File: rtl/pspin_hostmem_pkg.sv
// pspin_hostmem_pkg
// Shared definitions for the hostmem read-path blocks:
//   - AXI burst type encodings (FIXED/INCR/WRAP)
//   - AXI response encodings (OKAY/EXOKAY/SLVERR/DECERR)
//   - read-splitter FSM state enum
//   - largest sub-burst the downstream AXI4 port may carry
package pspin_hostmem_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  // AXI4 caps a burst at 256 beats.
  localparam int unsigned MAX_SUB_BEATS = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

endpackage

// File: rtl/pspin_hostmem_burst_calc.sv
// pspin_hostmem_burst_calc
// Purely combinational sizing of the next sub-burst of a parent read burst.
// INCR bursts are cut at the next BOUNDARY-aligned address and at 256 beats;
// FIXED/WRAP bursts are passed whole.
// Ports:
//   addr_i           current sub-burst start address (may be unaligned)
//   remaining_i      beats of the parent burst still to be requested (1..256)
//   size_i, burst_i  latched AR size / burst type
//   sub_beats_o      beats of the sub-burst starting at addr_i
//   next_addr_o      start address of the following sub-burst
//   next_remaining_o remaining_i minus sub_beats_o
module pspin_hostmem_burst_calc
  import pspin_hostmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned BOUNDARY   = 4096
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [8:0]            remaining_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [8:0]            sub_beats_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic [8:0]            next_remaining_o
);

  localparam int BND_LOG2 = $clog2(BOUNDARY);
  // Wide enough to hold BOUNDARY itself (size 0) and never below 13 bits.
  localparam int CW = ((BND_LOG2 + 2) > 13) ? (BND_LOG2 + 2) : 13;

  logic [ADDR_WIDTH-1:0] size_mask_s;
  logic [ADDR_WIDTH-1:0] aligned_s;
  logic [CW-1:0]         offset_s;
  logic [CW-1:0]         bytes_to_bnd_s;
  logic [CW-1:0]         beats_to_bnd_s;
  logic [CW-1:0]         beats_nz_s;
  logic [CW-1:0]         rem_ext_s;
  logic [CW-1:0]         min_rb_s;
  logic [CW-1:0]         min_all_s;
  logic [8:0]            sub_s;

  // Sub-burst length and follow-on address/remaining count.
  always_comb begin
    size_mask_s    = (ADDR_WIDTH'(1) << size_i) - ADDR_WIDTH'(1);
    // Only the boundary distance uses the size-aligned address.
    aligned_s      = addr_i & ~size_mask_s;
    offset_s       = CW'(aligned_s & ADDR_WIDTH'(BOUNDARY - 1));
    bytes_to_bnd_s = CW'(BOUNDARY) - offset_s;
    beats_to_bnd_s = bytes_to_bnd_s >> size_i;
    // An illegal size wider than BOUNDARY would give zero; never emit an empty sub-burst.
    beats_nz_s     = (beats_to_bnd_s == {CW{1'b0}}) ? CW'(1) : beats_to_bnd_s;
    rem_ext_s      = CW'(remaining_i);
    min_rb_s       = (beats_nz_s < rem_ext_s) ? beats_nz_s : rem_ext_s;
    min_all_s      = (min_rb_s > CW'(MAX_SUB_BEATS)) ? CW'(MAX_SUB_BEATS) : min_rb_s;
    if (burst_i == AXI_BURST_INCR) begin
      sub_s       = 9'(min_all_s);
      next_addr_o = addr_i + (ADDR_WIDTH'(sub_s) << size_i);
    end else begin
      sub_s       = remaining_i;
      next_addr_o = addr_i;
    end
    sub_beats_o      = sub_s;
    next_remaining_o = remaining_i - sub_s;
  end

endmodule

// File: rtl/pspin_hostmem_rd_splitter.sv
// pspin_hostmem_rd_splitter
// Splits one upstream AXI read burst at a time into BOUNDARY-respecting
// sub-bursts for the hostmem DMA read datapath, and stitches the returned
// beats back into a single upstream burst (rlast only on the final beat).
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   s_axi_ar* / s_axi_r* upstream read address / data channels
//   m_axi_ar* / m_axi_r* downstream read address / data channels
//   split_count          number of parent bursts that needed >= 2 sub-bursts
// Build option: define PSPIN_HOSTMEM_SPLIT_STATS_EN to implement split_count;
// otherwise it is tied to zero.
// s_axi_arready is registered: it rises on the first clock edge sampled with
// rstn high.
module pspin_hostmem_rd_splitter
  import pspin_hostmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned BOUNDARY   = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [31:0]           split_count
);

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            rem_q, rem_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  arvalid_q, arvalid_d;
  logic                  arready_q, arready_d;

  logic [8:0]            sub_beats_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [8:0]            next_rem_s;
  logic                  s_ar_hs_s;
  logic                  m_ar_hs_s;
  logic                  r_hs_s;

  pspin_hostmem_burst_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BOUNDARY   (BOUNDARY)
  ) u_burst_calc (
    .addr_i           (addr_q),
    .remaining_i      (rem_q),
    .size_i           (size_q),
    .burst_i          (burst_q),
    .sub_beats_o      (sub_beats_s),
    .next_addr_o      (next_addr_s),
    .next_remaining_o (next_rem_s)
  );

  assign s_ar_hs_s = s_axi_arvalid & arready_q;
  assign m_ar_hs_s = arvalid_q & m_axi_arready;
  assign r_hs_s    = (state_q == ST_DATA) & m_axi_rvalid & s_axi_rready;

  // Next-state and next-register computation.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    size_d    = size_q;
    burst_d   = burst_q;
    arvalid_d = arvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (s_ar_hs_s) begin
          id_d      = s_axi_arid;
          addr_d    = s_axi_araddr;
          rem_d     = {1'b0, s_axi_arlen} + 9'd1;
          size_d    = s_axi_arsize;
          burst_d   = s_axi_arburst;
          arvalid_d = 1'b1;
          state_d   = ST_ISSUE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (m_ar_hs_s) begin
          addr_d    = next_addr_s;
          rem_d     = next_rem_s;
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end else begin
          state_d   = ST_ISSUE;
        end
      end
      ST_DATA: begin
        if (r_hs_s && m_axi_rlast) begin
          if (rem_q != 9'd0) begin
            arvalid_d = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            state_d   = ST_IDLE;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
    arready_d = (state_d == ST_IDLE);
  end

  // State and context registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      id_q      <= {ID_WIDTH{1'b0}};
      addr_q    <= {ADDR_WIDTH{1'b0}};
      rem_q     <= 9'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'd0;
      arvalid_q <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      arvalid_q <= arvalid_d;
      arready_q <= arready_d;
    end
  end

  assign s_axi_arready = arready_q;

  // Address fields come straight from registers, so they stay stable while arvalid waits.
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(sub_beats_s - 9'd1);
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = burst_q;

  // R is only opened in DATA; stray downstream beats are back-pressured elsewhere.
  assign s_axi_rvalid = (state_q == ST_DATA) & m_axi_rvalid;
  assign m_axi_rready = (state_q == ST_DATA) & s_axi_rready;
  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  // rem_q is already decremented for the sub-burst in flight, so zero marks the last one.
  assign s_axi_rlast  = m_axi_rlast & (rem_q == 9'd0);

`ifdef PSPIN_HOSTMEM_SPLIT_STATS_EN
  logic        first_q, first_d;
  logic [31:0] split_cnt_q, split_cnt_d;

  // A parent is split exactly when its first sub-burst leaves beats behind.
  always_comb begin
    first_d     = first_q;
    split_cnt_d = split_cnt_q;
    if (s_ar_hs_s) begin
      first_d = 1'b1;
    end else if (m_ar_hs_s) begin
      first_d = 1'b0;
      if (first_q && (next_rem_s != 9'd0)) begin
        split_cnt_d = split_cnt_q + 32'd1;
      end else begin
        split_cnt_d = split_cnt_q;
      end
    end else begin
      first_d = first_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      first_q     <= 1'b0;
      split_cnt_q <= 32'd0;
    end else begin
      first_q     <= first_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign split_count = split_cnt_q;
`else
  assign split_count = 32'd0;
`endif

endmodule

// File: tb/tb_pspin_hostmem_rd_splitter.sv
module tb_pspin_hostmem_rd_splitter;
  import pspin_hostmem_pkg::*;

  localparam int AW  = 64;
  localparam int DW  = 512;
  localparam int IW  = 8;
  localparam int BND = 4096;

  logic          clk = 1'b0;
  logic          rstn;
  logic [IW-1:0] s_axi_arid;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic [1:0]    s_axi_arburst;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
  logic          s_axi_rvalid;
  logic          s_axi_rready;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [31:0]   split_count;

  pspin_hostmem_rd_splitter dut (
    .clk(clk), .rstn(rstn),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .split_count(split_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } r_t;

  ar_t           exp_ar_q[$];
  r_t            exp_r_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [31:0]   exp_splits = 32'd0;
  logic [AW-1:0] err_addr_g = {AW{1'b1}};
  bit            rand_err_g = 1'b0;
  int            rr_mode = 0;

  // Downstream memory content: a function of sub-burst address and beat index.
  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
    logic [31:0] w;
    w = a[31:0] ^ a[63:32] ^ (32'(b) * 32'h9E37_79B9);
    return {16{w}};
  endfunction

  // Downstream error behaviour: forced SLVERR at err_addr_g, optional DECERR sprinkle.
  function automatic logic [1:0] beat_resp(input logic [AW-1:0] a, input int b);
    if (a == err_addr_g) return 2'd2;
    if (rand_err_g && (((int'(a[9:6]) + b) % 5) == 0)) return 2'd3;
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Reference model: walk the parent burst with plain integer arithmetic.
  task automatic model_parent(input ar_t p);
    longint unsigned a, al, btb, sub, rem;
    int  nsub;
    ar_t ea;
    r_t  er;
    a    = p.addr;
    rem  = longint'(p.len) + 1;
    nsub = 0;
    while (rem > 0) begin
      if (p.burst == AXI_BURST_INCR) begin
        al  = a - (a % (64'd1 << p.size));
        btb = (BND - (al % BND)) / (64'd1 << p.size);
        sub = rem;
        if (btb < sub) sub = btb;
        if (sub > 256) sub = 256;
      end else begin
        sub = rem;
      end
      ea.addr = a; ea.len = 8'(sub - 1); ea.id = p.id; ea.size = p.size; ea.burst = p.burst;
      exp_ar_q.push_back(ea);
      for (int b = 0; b < int'(sub); b++) begin
        er.data = beat_data(a, b);
        er.resp = beat_resp(a, b);
        er.last = (b == int'(sub) - 1) && (rem == sub);
        er.id   = p.id;
        exp_r_q.push_back(er);
      end
      if (p.burst == AXI_BURST_INCR) a = a + sub * (64'd1 << p.size);
      rem = rem - sub;
      nsub++;
    end
    if (nsub >= 2) exp_splits = exp_splits + 32'd1;
  endtask

  // Present a parent AR; the model is fed at the cycle the handshake is seen.
  task automatic issue_ar(input ar_t p);
    int t;
    @(posedge clk); #1;
    s_axi_arid = p.id; s_axi_araddr = p.addr; s_axi_arlen = p.len;
    s_axi_arsize = p.size; s_axi_arburst = p.burst; s_axi_arvalid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_axi_arready && t < 200);
    if (!s_axi_arready) begin
      n_vec++; n_err++;
      $display("FAIL ar_accept_timeout: got arready=0, required 1 within 200 cycles");
    end else begin
      model_parent(p);
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_ar_q.size() != 0 || exp_r_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_ar_q.size() != 0 || exp_r_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_drain_timeout: got %0d AR / %0d R outstanding, required 0",
               name, exp_ar_q.size(), exp_r_q.size());
      exp_ar_q.delete(); exp_r_q.delete();
    end
    @(negedge clk);
`ifdef PSPIN_HOSTMEM_SPLIT_STATS_EN
    check({name, "_split_count"}, 64'(split_count), 64'(exp_splits));
`else
    check({name, "_split_count"}, 64'(split_count), 64'd0);
`endif
  endtask

  task automatic run_parent(input string name, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [IW-1:0] id);
    ar_t p;
    p.addr = addr; p.len = len; p.size = size; p.burst = burst; p.id = id;
    issue_ar(p);
    drain(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_arready"}, 64'(s_axi_arready), 64'd0);
    check({name, "_m_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    check({name, "_s_rvalid"}, 64'(s_axi_rvalid), 64'd0);
    check({name, "_m_rready"}, 64'(m_axi_rready), 64'd0);
    check({name, "_split_count"}, 64'(split_count), 64'd0);
  endtask

  // Downstream slave: one sub-burst at a time, random AR and R valid delays.
  initial begin
    bit            busy;
    int            total, bi;
    logic [AW-1:0] saddr;
    logic [IW-1:0] sid;
    logic          n_arready, n_rvalid;
    busy = 1'b0; total = 0; bi = 0; saddr = {AW{1'b0}}; sid = {IW{1'b0}};
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = {DW{1'b0}};
    m_axi_rresp = 2'd0; m_axi_rlast = 1'b0; m_axi_rid = {IW{1'b0}};
    forever begin
      @(negedge clk);
      if (!rstn) begin
        busy = 1'b0; n_arready = 1'b0; n_rvalid = 1'b0;
      end else begin
        if (m_axi_rvalid && m_axi_rready) begin
          bi++;
          if (bi == total) busy = 1'b0;
        end
        if (m_axi_arvalid && m_axi_arready) begin
          busy = 1'b1; saddr = m_axi_araddr; total = int'(m_axi_arlen) + 1; bi = 0;
          sid = m_axi_arid; n_arready = 1'b0;
        end else begin
          n_arready = !busy && m_axi_arvalid && ($urandom_range(0, 2) != 0);
        end
        if (busy && m_axi_rvalid && !m_axi_rready) n_rvalid = 1'b1;
        else n_rvalid = busy && ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      m_axi_arready = n_arready;
      m_axi_rvalid  = n_rvalid;
      m_axi_rdata   = beat_data(saddr, bi);
      m_axi_rresp   = beat_resp(saddr, bi);
      m_axi_rlast   = (bi == total - 1);
      m_axi_rid     = sid;
    end
  end

  // Upstream R back-pressure: 0 = always ready, 1 = random, 2 = toggle each cycle.
  initial begin
    s_axi_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = ($urandom_range(0, 1) == 1);
        default: s_axi_rready = !s_axi_rready;
      endcase
    end
  end

  // Scoreboard monitor: compares every downstream AR and upstream R handshake.
  initial begin
    ar_t ea;
    r_t  er;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (m_axi_arvalid && m_axi_arready) begin
          n_vec++;
          if (exp_ar_q.size() == 0) begin
            n_err++;
            $display("FAIL ar_unexpected: got addr=%h len=%0d, required no sub-burst", m_axi_araddr, m_axi_arlen);
          end else begin
            ea = exp_ar_q.pop_front();
            if (m_axi_araddr !== ea.addr || m_axi_arlen !== ea.len || m_axi_arid !== ea.id ||
                m_axi_arsize !== ea.size || m_axi_arburst !== ea.burst) begin
              n_err++;
              $display("FAIL ar_sub: got addr=%h len=%0d id=%h size=%0d burst=%0d, required addr=%h len=%0d id=%h size=%0d burst=%0d",
                       m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arsize, m_axi_arburst,
                       ea.addr, ea.len, ea.id, ea.size, ea.burst);
            end
          end
        end
        if (s_axi_rvalid && s_axi_rready) begin
          n_vec++;
          if (exp_r_q.size() == 0) begin
            n_err++;
            $display("FAIL r_unexpected: got rlast=%0d resp=%0d, required no beat", s_axi_rlast, s_axi_rresp);
          end else begin
            er = exp_r_q.pop_front();
            if (s_axi_rdata !== er.data || s_axi_rresp !== er.resp || s_axi_rlast !== er.last ||
                s_axi_rid !== er.id) begin
              n_err++;
              $display("FAIL r_beat: got data[31:0]=%h resp=%0d last=%0d id=%h, required data[31:0]=%h resp=%0d last=%0d id=%h",
                       s_axi_rdata[31:0], s_axi_rresp, s_axi_rlast, s_axi_rid,
                       er.data[31:0], er.resp, er.last, er.id);
            end
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus.
  initial begin
    ar_t p;
    int  t;
    rstn = 1'b0; s_axi_arvalid = 1'b0; s_axi_arid = {IW{1'b0}}; s_axi_araddr = {AW{1'b0}};
    s_axi_arlen = 8'd0; s_axi_arsize = 3'd0; s_axi_arburst = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_arready", 64'(s_axi_arready), 64'd1);

    rr_mode = 0;
    run_parent("split_0f80", 64'h0F80, 8'd7, 3'd6, AXI_BURST_INCR, 8'h11);
    run_parent("nosplit_2000", 64'h2000, 8'd63, 3'd6, AXI_BURST_INCR, 8'h22);
    run_parent("single_0fc0", 64'h0FC0, 8'd0, 3'd6, AXI_BURST_INCR, 8'h33);
    run_parent("wrap_0fc0", 64'h0FC0, 8'd3, 3'd6, AXI_BURST_WRAP, 8'h44);
    err_addr_g = 64'h0F80;
    run_parent("slverr_0f80", 64'h0F80, 8'd7, 3'd6, AXI_BURST_INCR, 8'h55);
    err_addr_g = {AW{1'b1}};
    run_parent("end_at_bnd", 64'h0E00, 8'd7, 3'd6, AXI_BURST_INCR, 8'h66);
    run_parent("size0_256", 64'h0F00, 8'd255, 3'd0, AXI_BURST_INCR, 8'h77);

    rr_mode = 1; rand_err_g = 1'b1;
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel     = $urandom_range(0, 9);
      p.size  = 3'($urandom_range(0, 6));
      p.id    = 8'($urandom);
      p.addr  = {32'($urandom_range(0, 3)), 18'd0, 14'($urandom)};
      if ($urandom_range(0, 4) != 0) p.addr = p.addr & ~((64'd1 << p.size) - 64'd1);
      if (sel < 7) begin
        p.burst = AXI_BURST_INCR; p.len = 8'($urandom_range(0, 255));
      end else if (sel < 9) begin
        p.burst = AXI_BURST_WRAP; p.len = 8'((2 << $urandom_range(0, 3)) - 1);
      end else begin
        p.burst = AXI_BURST_FIXED; p.len = 8'($urandom_range(0, 15));
      end
      issue_ar(p);
      drain("random");
    end

    // Reset in the middle of the second sub-burst with toggling rready.
    rr_mode = 2; rand_err_g = 1'b0;
    p.addr = 64'h0F80; p.len = 8'd7; p.size = 3'd6; p.burst = AXI_BURST_INCR; p.id = 8'h99;
    issue_ar(p);
    t = 0;
    while (exp_r_q.size() > 4 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_r_q.size() > 4) begin
      n_vec++; n_err++;
      $display("FAIL midburst_progress: got %0d beats outstanding, required at most 4", exp_r_q.size());
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midburst_reset");
    exp_ar_q.delete(); exp_r_q.delete();
    exp_splits = 32'd0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_reset_arready", 64'(s_axi_arready), 64'd1);
    rr_mode = 0;
    run_parent("after_reset_split", 64'h1FC0, 8'd3, 3'd6, AXI_BURST_INCR, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
